bf16_normalize: RTL and testbench

Post-add normalization and rounding stage of the bfloat16 adder datapath. It consumes the 11-bit raw significand sum from the significand adder, together with the common (larger) exponent and the result sign. It normalizes the sum with an iterative one-bit-per-cycle shifter and rounds to nearest-even. It emits a packed 16-bit bfloat16 word and flags through valid/ready handshakes on both sides.

---
 rtl/bf16_pkg.sv | 27 ++
 rtl/bf16_normalize_if.sv | 29 ++
 rtl/bf16_round.sv | 51 +++++
 rtl/bf16_normalize.sv | 150 +++++++++++++++
 tb/tb_bf16_normalize.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/bf16_pkg.sv
// Shared definitions for the bfloat16 adder normalization stage.
//   BF16_EXP_W / BF16_MANT_W : bf16 field widths
//   SUM_W                    : raw significand sum width {carry, hidden, mant[6:0], guard, sticky}
//   EXP_MAX                  : all-ones exponent (inf/NaN)
//   norm_state_e             : normalization FSM states
//   bf16_t                   : packed bf16 word {sign, exp, mant}
package bf16_pkg;

  localparam int unsigned BF16_EXP_W  = 8;
  localparam int unsigned BF16_MANT_W = 7;
  localparam int unsigned SUM_W       = 11;
  localparam logic [BF16_EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    StIdle,
    StNorm,
    StRound,
    StHold
  } norm_state_e;

  typedef struct packed {
    logic                   sign;
    logic [BF16_EXP_W-1:0]  exp;
    logic [BF16_MANT_W-1:0] mant;
  } bf16_t;

endpackage

// File: rtl/bf16_normalize_if.sv
// Handshake bundle for bf16_normalize.
//   Input side : in_valid/in_ready with in_sign, in_exp, in_sum
//   Output side: out_valid/out_ready with out_data, out_ovf, out_uf
//   master = producer/consumer environment, slave = the normalize stage.
interface bf16_normalize_if;
  import bf16_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic                  in_sign;
  logic [BF16_EXP_W-1:0] in_exp;
  logic [SUM_W-1:0]      in_sum;
  logic                  out_valid;
  logic                  out_ready;
  logic [15:0]           out_data;
  logic                  out_ovf;
  logic                  out_uf;

  modport master (
    output in_valid, in_sign, in_exp, in_sum, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, out_uf
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_sum, out_ready,
    output in_ready, out_valid, out_data, out_ovf, out_uf
  );

endinterface

// File: rtl/bf16_round.sv
// Combinational round-to-nearest-even and pack.
//   sig_i    : normalized significand (hidden bit at [9], mant [8:2], guard [1], sticky [0])
//   exp_i    : 9-bit biased exponent
//   sign_i   : result sign
//   sticky_i : OR of bits shifted out during normalization
//   data_o   : packed bf16 result, saturated to infinity on overflow
//   ovf_o    : result exponent reached 255 after rounding
module bf16_round
  import bf16_pkg::*;
(
  input  logic [SUM_W-1:0] sig_i,
  input  logic [8:0]       exp_i,
  input  logic             sign_i,
  input  logic             sticky_i,
  output logic [15:0]      data_o,
  output logic             ovf_o
);

  logic                 lsb;
  logic                 guard;
  logic                 sticky_all;
  logic                 round_up;
  logic [BF16_MANT_W:0] mant_inc;
  logic [8:0]           exp_rnd;
  bf16_t                res;
  logic                 unused_sig;

  // Carry and hidden bits are already resolved by the normalizer.
  assign unused_sig = ^sig_i[10:9];

  always_comb begin
    lsb        = sig_i[2];
    guard      = sig_i[1];
    sticky_all = sig_i[0] | sticky_i;
    round_up   = guard & (sticky_all | lsb);
    // A carry out of the 7-bit mantissa leaves mant_inc[6:0] at zero already.
    mant_inc   = {1'b0, sig_i[8:2]} + {{BF16_MANT_W{1'b0}}, round_up};
    exp_rnd    = exp_i + {8'd0, mant_inc[BF16_MANT_W]};
    res.sign   = sign_i;
    res.exp    = exp_rnd[7:0];
    res.mant   = mant_inc[BF16_MANT_W-1:0];
    ovf_o      = 1'b0;
    if (exp_rnd >= {1'b0, EXP_MAX}) begin
      res.exp  = EXP_MAX;
      res.mant = '0;
      ovf_o    = 1'b1;
    end
    data_o = res;
  end

endmodule

// File: rtl/bf16_normalize.sv
// Post-add normalization and rounding stage of the bf16 adder.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of bf16_normalize_if (input word in, packed bf16 + flags out)
// One operation in flight: IDLE accepts, NORM shifts one bit per cycle, ROUND registers
// the packed result, HOLD presents it until out_ready.
module bf16_normalize
  import bf16_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  bf16_normalize_if.slave  bus
);

  norm_state_e      state_q, state_d;
  logic [SUM_W-1:0] sig_q, sig_d;
  logic [8:0]       exp_q, exp_d;
  logic             sign_q, sign_d;
  logic             sticky_q, sticky_d;
  // Bypass covers specials, exact zero and underflow flush: result is fixed, no rounding.
  logic             bypass_q, bypass_d;
  logic [15:0]      byp_data_q, byp_data_d;
  logic             uf_q, uf_d;
  logic [15:0]      out_data_q, out_data_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_uf_q, out_uf_d;

  logic [15:0]      rnd_data;
  logic             rnd_ovf;

  bf16_round u_round (
    .sig_i    (sig_q),
    .exp_i    (exp_q),
    .sign_i   (sign_q),
    .sticky_i (sticky_q),
    .data_o   (rnd_data),
    .ovf_o    (rnd_ovf)
  );

  always_comb begin
    state_d    = state_q;
    sig_d      = sig_q;
    exp_d      = exp_q;
    sign_d     = sign_q;
    sticky_d   = sticky_q;
    bypass_d   = bypass_q;
    byp_data_d = byp_data_q;
    uf_d       = uf_q;
    out_data_d = out_data_q;
    out_ovf_d  = out_ovf_q;
    out_uf_d   = out_uf_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          sign_d     = bus.in_sign;
          exp_d      = {1'b0, bus.in_exp};
          sig_d      = bus.in_sum;
          sticky_d   = bus.in_sum[0];
          bypass_d   = 1'b0;
          uf_d       = 1'b0;
          byp_data_d = '0;
          if (bus.in_exp == EXP_MAX) begin
            bypass_d   = 1'b1;
            byp_data_d = {bus.in_sign, EXP_MAX, bus.in_sum[8:2]};
            state_d    = StRound;
          end else if (bus.in_sum == '0) begin
            bypass_d   = 1'b1;
            byp_data_d = {bus.in_sign, 15'h0};
            state_d    = StRound;
          end else begin
            state_d = StNorm;
          end
        end
      end
      StNorm: begin
        if (sig_q[10]) begin
          sig_d    = {1'b0, sig_q[10:1]};
          sticky_d = sticky_q | sig_q[0];
          exp_d    = exp_q + 9'd1;
          state_d  = StRound;
        end else if (sig_q[9]) begin
          state_d = StRound;
        end else if (exp_q <= 9'd1) begin
          // Next shift would need a denormal; flush. Exponent 0 only arises from a
          // degenerate capture and is flushed too rather than wrapping.
          bypass_d   = 1'b1;
          uf_d       = 1'b1;
          byp_data_d = {sign_q, 15'h0};
          state_d    = StRound;
        end else begin
          sig_d = {sig_q[9:0], 1'b0};
          exp_d = exp_q - 9'd1;
        end
      end
      StRound: begin
        if (bypass_q) begin
          out_data_d = byp_data_q;
          out_ovf_d  = 1'b0;
          out_uf_d   = uf_q;
        end else begin
          out_data_d = rnd_data;
          out_ovf_d  = rnd_ovf;
          out_uf_d   = 1'b0;
        end
        state_d = StHold;
      end
      StHold: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      sig_q      <= '0;
      exp_q      <= '0;
      sign_q     <= 1'b0;
      sticky_q   <= 1'b0;
      bypass_q   <= 1'b0;
      byp_data_q <= '0;
      uf_q       <= 1'b0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
      out_uf_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sig_q      <= sig_d;
      exp_q      <= exp_d;
      sign_q     <= sign_d;
      sticky_q   <= sticky_d;
      bypass_q   <= bypass_d;
      byp_data_q <= byp_data_d;
      uf_q       <= uf_d;
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
      out_uf_q   <= out_uf_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StHold);
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.out_uf    = out_uf_q;

endmodule

// File: tb/tb_bf16_normalize.sv
// Self-checking bench for bf16_normalize: table of vectors with a scoreboard queue,
// plus hand-written backpressure and mid-NORM reset sequences.
module tb_bf16_normalize;
  import bf16_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bf16_normalize_if bus ();

  bf16_normalize dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [10:0] sum;
    logic [15:0] data;
    logic        ovf;
    logic        uf;
    int          lat;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic        ovf;
    logic        uf;
    int          lat;
  } exp_t;

  localparam int NVEC = 15;
  vec_t vecs[NVEC];
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  // Called at a negedge with the stage idle; returns at the negedge of cycle 1.
  task automatic drive(input logic s, input logic [7:0] e, input logic [10:0] sum);
    bus.in_valid = 1'b1;
    bus.in_sign  = s;
    bus.in_exp   = e;
    bus.in_sum   = sum;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!bus.out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic compare_out(input string name, input int cyc);
    exp_t e;
    check({name, " out_valid"}, 32'(bus.out_valid), 32'd1);
    if (sb_q.size() == 0) begin
      check({name, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({name, " latency"}, 32'(cyc), 32'(e.lat));
      check({name, " data"}, 32'(bus.out_data), 32'(e.data));
      check({name, " ovf"}, 32'(bus.out_ovf), 32'(e.ovf));
      check({name, " uf"}, 32'(bus.out_uf), 32'(e.uf));
    end
  endtask

  task automatic release_out(input string name);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({name, " in_ready after accept"}, 32'(bus.in_ready), 32'd1);
    check({name, " out_valid after accept"}, 32'(bus.out_valid), 32'd0);
  endtask

  task automatic run_vec(input int i);
    int cyc;
    string name;
    name = $sformatf("vec%0d", i);
    sb_q.push_back('{data: vecs[i].data, ovf: vecs[i].ovf, uf: vecs[i].uf, lat: vecs[i].lat});
    drive(vecs[i].sign, vecs[i].exp, vecs[i].sum);
    wait_valid(cyc);
    compare_out(name, cyc);
    release_out(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;

    //           sign exp     sum      data     ovf  uf   lat
    vecs[0]  = '{1'b0, 8'd127, 11'h200, 16'h3F80, 1'b0, 1'b0, 3};  // plain
    vecs[1]  = '{1'b0, 8'd127, 11'h400, 16'h4000, 1'b0, 1'b0, 3};  // carry
    vecs[2]  = '{1'b0, 8'd254, 11'h400, 16'h7F80, 1'b1, 1'b0, 3};  // carry overflow
    vecs[3]  = '{1'b0, 8'd127, 11'h080, 16'h3E80, 1'b0, 1'b0, 5};  // two left shifts
    vecs[4]  = '{1'b0, 8'd2,   11'h080, 16'h0000, 1'b0, 1'b1, 4};  // underflow flush
    vecs[5]  = '{1'b0, 8'd127, 11'h206, 16'h3F82, 1'b0, 1'b0, 3};  // tie, lsb=1
    vecs[6]  = '{1'b0, 8'd127, 11'h202, 16'h3F80, 1'b0, 1'b0, 3};  // tie, lsb=0
    vecs[7]  = '{1'b0, 8'd127, 11'h203, 16'h3F81, 1'b0, 1'b0, 3};  // above half
    vecs[8]  = '{1'b1, 8'd127, 11'h000, 16'h8000, 1'b0, 1'b0, 2};  // signed zero
    vecs[9]  = '{1'b0, 8'd255, 11'h204, 16'h7F81, 1'b0, 1'b0, 2};  // special passthrough
    vecs[10] = '{1'b0, 8'd254, 11'h3FE, 16'h7F80, 1'b1, 1'b0, 3};  // round into overflow
    vecs[11] = '{1'b0, 8'd127, 11'h3FE, 16'h4000, 1'b0, 1'b0, 3};  // mantissa carry
    vecs[12] = '{1'b1, 8'd130, 11'h240, 16'hC110, 1'b0, 1'b0, 3};  // negative normal
    vecs[13] = '{1'b0, 8'd127, 11'h406, 16'h4001, 1'b0, 1'b0, 3};  // carry then round up
    vecs[14] = '{1'b0, 8'd127, 11'h001, 16'h3B00, 1'b0, 1'b0, 12}; // nine left shifts

    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_exp    = '0;
    bus.in_sum    = '0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("reset in_ready", 32'(bus.in_ready), 32'd1);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset out_data", 32'(bus.out_data), 32'h0);
    check("reset out_ovf", 32'(bus.out_ovf), 32'd0);
    check("reset out_uf", 32'(bus.out_uf), 32'd0);

    for (int i = 0; i < NVEC; i++) begin
      run_vec(i);
    end

    // Backpressure: result held stable, stage busy, stray in_valid ignored.
    sb_q.push_back('{data: 16'h3F81, ovf: 1'b0, uf: 1'b0, lat: 3});
    drive(1'b0, 8'd127, 11'h203);
    wait_valid(cyc);
    compare_out("bp", cyc);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        bus.in_valid = 1'b1;
        bus.in_sign  = 1'b1;
        bus.in_exp   = 8'd127;
        bus.in_sum   = 11'h400;
      end
      @(negedge clk);
      check($sformatf("bp hold%0d data", i), 32'(bus.out_data), 32'h3F81);
      check($sformatf("bp hold%0d out_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("bp hold%0d in_ready", i), 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    release_out("bp");
    repeat (4) @(negedge clk);
    check("bp stray in_valid ignored", 32'(bus.out_valid), 32'd0);
    check("bp idle after stray", 32'(bus.in_ready), 32'd1);

    // Reset in the middle of a long NORM sequence discards the operation.
    drive(1'b0, 8'd127, 11'h001);
    repeat (2) @(negedge clk);
    check("mid-norm busy", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid-norm rst in_ready", 32'(bus.in_ready), 32'd1);
    check("mid-norm rst out_valid", 32'(bus.out_valid), 32'd0);
    check("mid-norm rst out_data", 32'(bus.out_data), 32'h0);
    repeat (15) @(negedge clk);
    check("mid-norm discarded", 32'(bus.out_valid), 32'd0);

    // Normal operation resumes after reset.
    run_vec(7);

    check("scoreboard drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
